alu_flags: RTL
==============

Name: alu_flags

Overview:
- Execute stage directly downstream of the register file. Consumes DX_OUT (operand A) and either DY_OUT or the IR immediate (operand B).
- Computes an 8-bit result that feeds back to the register file write-data input.
- Holds the architectural C and Z flags, plus a shadow C/Z pair used to save and restore flags around interrupts.
- Datapath is combinational. Flag storage is sequential and driven by control-unit strobes.

Parameters:
- WIDTH, 8, operand/result width; only 8 is supported (flags and shifts are defined for 8 bits).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- A  in  8  operand A, from register-file DX_OUT.
- DY  in  8  register operand, from register-file DY_OUT.
- IR  in  18  instruction register; IR[7:0] is the immediate.
- OPY_SEL  in  1  0: B=DY; 1: B=IR[7:0].
- ALU_SEL  in  4  operation select.
- FLG_C_LD  in  1  load C from next-C source.
- FLG_Z_LD  in  1  load Z from next-Z source.
- FLG_C_SET  in  1  force C=1.
- FLG_C_CLR  in  1  force C=0.
- FLG_LD_SEL  in  1  0: next-C/Z source is ALU; 1: source is shadow flags.
- FLG_SHAD_LD  in  1  copy current C/Z into shadow.
- RESULT  out  8  combinational ALU result.
- ALU_C  out  1  combinational carry/borrow out.
- ALU_Z  out  1  combinational zero, (RESULT==0).
- C_FLAG  out  1  registered carry flag.
- Z_FLAG  out  1  registered zero flag.

Behaviour:
- Cin = C_FLAG (registered value). B = OPY_SEL ? IR[7:0] : DY.
- ALU_SEL operations (R = RESULT, C = ALU_C):
  - 0 ADD: {C,R} = A+B.
  - 1 ADDC: {C,R} = A+B+Cin.
  - 2 SUB: R = A-B mod 256; C = 1 iff A<B (borrow).
  - 3 SUBC: R = A-B-Cin mod 256; C = 1 iff A < B+Cin.
  - 4 CMP: same as SUB. The control unit does not write R back.
  - 5 AND, 6 OR, 7 EXOR: bitwise, C=0.
  - 8 TEST: R = A&B, C=0.
  - 9 LSL: R = {A[6:0],Cin}, C = A[7].
  - 10 LSR: R = {Cin,A[7:1]}, C = A[0].
  - 11 ROL: R = {A[6:0],A[7]}, C = A[7].
  - 12 ROR: R = {A[0],A[7:1]}, C = A[0].
  - 13 ASR: R = {A[7],A[7:1]}, C = A[0].
  - 14 MOV: R = B, C = Cin.
  - 15: R = 0, C = 0.
- ALU_Z = (R == 8'h00) for every op, including CMP/TEST.
- Arithmetic is computed 9 bits wide. No signed-overflow flag exists.
- C_FLAG next-state priority at posedge:
  1. RST → 0.
  2. FLG_C_CLR → 0.
  3. FLG_C_SET → 1.
  4. FLG_C_LD → (FLG_LD_SEL ? SHAD_C : ALU_C).
  5. Otherwise hold.
  - CLR and SET asserted together: CLR wins.
- Z_FLAG next-state at posedge:
  1. RST → 0.
  2. FLG_Z_LD → (FLG_LD_SEL ? SHAD_Z : ALU_Z).
  3. Otherwise hold.
  - SET/CLR do not affect Z.
- Shadow flags at posedge:
  1. RST → SHAD_C=0, SHAD_Z=0.
  2. FLG_SHAD_LD → SHAD_C=C_FLAG, SHAD_Z=Z_FLAG (pre-edge values).
  3. Otherwise hold.
- Simultaneous FLG_SHAD_LD and flag load in the same cycle: the shadow captures the old flags, and C/Z take their new values. This is a single-edge swap, with no ordering hazard.
- FLG_LD_SEL=1 with FLG_SHAD_LD=1: C/Z load the old shadow values while the shadow takes the old flags.
- Latency:
  - RESULT/ALU_C/ALU_Z are zero-cycle, settling within the same cycle.
  - C_FLAG/Z_FLAG update one edge after their strobe.
  - ADDC/SUBC/LSL/LSR/MOV use the flag value present before that edge.
- Reset:
  - All registered outputs and shadows are 0 in the cycle after RST is sampled high.
  - RST asserted alongside any strobe: reset wins.
  - RESULT is not reset; it tracks its inputs.

Test Plan:
- ADD A=8'hFF, DY=8'h01, OPY_SEL=0, C_LD=Z_LD=1 → RESULT=00, ALU_C=1, ALU_Z=1. After the edge, C_FLAG=1, Z_FLAG=1.
- With C_FLAG=1: ADDC A=8'h10, IR[7:0]=8'h20, OPY_SEL=1 → RESULT=31, ALU_C=0. SUBC A=8'h05, B=8'h05 → RESULT=FF, ALU_C=1.
- Shifts with C_FLAG=1, A=8'h81:
  - LSL → 03, C=1.
  - LSR → C0, C=1.
  - ROR → C0, C=1.
  - ASR → C0, C=1.
  - ROL → 03, C=1.
  - Repeat LSL with C_FLAG=0 → 02.
- FLG_C_SET and FLG_C_CLR asserted together → C_FLAG=0. Then SET alone → C_FLAG=1, with Z_FLAG unchanged.
- Flags C=1, Z=0:
  - FLG_SHAD_LD → shadow holds 1/0.
  - Then CMP A=3, B=3 with loads → C=0, Z=1.
  - Then FLG_LD_SEL=1, C_LD=Z_LD=1 → C_FLAG=1, Z_FLAG=0 restored.
- Flags set to 1/1, then RST=1 asserted together with FLG_C_SET and FLG_SHAD_LD → next cycle C_FLAG=0, Z_FLAG=0. A subsequent restore (LD_SEL=1) yields 0/0.

Source files
------------

// File: rtl/alu_flags_if.sv
// Operand, control-strobe and result bundle between the control unit / register
// file side (master) and the execute-stage ALU with its flag registers (slave).
interface alu_flags_if;
    logic [7:0]  a;
    logic [7:0]  dy;
    logic [17:0] ir;
    logic        opy_sel;
    logic [3:0]  alu_sel;
    logic        flg_c_ld;
    logic        flg_z_ld;
    logic        flg_c_set;
    logic        flg_c_clr;
    logic        flg_ld_sel;
    logic        flg_shad_ld;
    logic [7:0]  result;
    logic        alu_c;
    logic        alu_z;
    logic        c_flag;
    logic        z_flag;

    modport master (
        output a, dy, ir, opy_sel, alu_sel,
        output flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_ld_sel, flg_shad_ld,
        input  result, alu_c, alu_z, c_flag, z_flag
    );

    modport slave (
        input  a, dy, ir, opy_sel, alu_sel,
        input  flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_ld_sel, flg_shad_ld,
        output result, alu_c, alu_z, c_flag, z_flag
    );
endinterface

// File: rtl/alu_flags.sv
// Execute-stage 8-bit ALU: combinational result/carry/zero, plus registered C/Z
// flags and a shadow C/Z pair for saving and restoring flags around interrupts.
module alu_flags #(
    parameter int WIDTH = 8
) (
    input  logic CLK,
    input  logic RST,
    alu_flags_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB  = 4'd2,  OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_EXOR = 4'd7,
        OP_TEST = 4'd8,  OP_LSL  = 4'd9,  OP_LSR  = 4'd10, OP_ROL  = 4'd11,
        OP_ROR  = 4'd12, OP_ASR  = 4'd13, OP_MOV  = 4'd14, OP_ZERO = 4'd15
    } alu_op_e;

    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   wide;
    logic             cout;
    logic             cin;
    alu_op_e          op;

    logic c_flag_reg, c_flag_next;
    logic z_flag_reg, z_flag_next;
    logic shad_c_reg, shad_c_next;
    logic shad_z_reg, shad_z_next;

    // Only the immediate byte of IR is relevant to the execute stage.
    logic unused_ir;
    assign unused_ir = ^bus.ir[17:8];

    assign cin = c_flag_reg;
    assign op  = alu_op_e'(bus.alu_sel);
    assign opb = bus.opy_sel ? bus.ir[7:0] : bus.dy;

    // Subtractions are done 9 bits wide so bit 8 of the difference is the borrow.
    always_comb begin
        wide = '0;
        res  = '0;
        cout = 1'b0;
        unique case (op)
            OP_ADD: begin
                wide = {1'b0, bus.a} + {1'b0, opb};
                {cout, res} = wide;
            end
            OP_ADDC: begin
                wide = {1'b0, bus.a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
                {cout, res} = wide;
            end
            OP_SUB, OP_CMP: begin
                wide = {1'b0, bus.a} - {1'b0, opb};
                {cout, res} = wide;
            end
            OP_SUBC: begin
                wide = {1'b0, bus.a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
                {cout, res} = wide;
            end
            OP_AND, OP_TEST: res = bus.a & opb;
            OP_OR:           res = bus.a | opb;
            OP_EXOR:         res = bus.a ^ opb;
            OP_LSL: begin
                res  = {bus.a[6:0], cin};
                cout = bus.a[7];
            end
            OP_LSR: begin
                res  = {cin, bus.a[7:1]};
                cout = bus.a[0];
            end
            OP_ROL: begin
                res  = {bus.a[6:0], bus.a[7]};
                cout = bus.a[7];
            end
            OP_ROR: begin
                res  = {bus.a[0], bus.a[7:1]};
                cout = bus.a[0];
            end
            OP_ASR: begin
                res  = {bus.a[7], bus.a[7:1]};
                cout = bus.a[0];
            end
            OP_MOV: begin
                res  = opb;
                cout = cin;
            end
            OP_ZERO: begin
                res  = '0;
                cout = 1'b0;
            end
            default: begin
                res  = '0;
                cout = 1'b0;
            end
        endcase
    end

    assign bus.result = res;
    assign bus.alu_c  = cout;
    assign bus.alu_z  = (res == '0);

    // Shadow capture and flag load share one edge, so a save+restore swap is
    // hazard-free: each side sees the other's pre-edge value.
    always_comb begin
        c_flag_next = c_flag_reg;
        z_flag_next = z_flag_reg;
        shad_c_next = shad_c_reg;
        shad_z_next = shad_z_reg;

        if (bus.flg_c_clr) begin
            c_flag_next = 1'b0;
        end else if (bus.flg_c_set) begin
            c_flag_next = 1'b1;
        end else if (bus.flg_c_ld) begin
            c_flag_next = bus.flg_ld_sel ? shad_c_reg : cout;
        end

        if (bus.flg_z_ld) begin
            z_flag_next = bus.flg_ld_sel ? shad_z_reg : (res == '0);
        end

        if (bus.flg_shad_ld) begin
            shad_c_next = c_flag_reg;
            shad_z_next = z_flag_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_flag_reg <= 1'b0;
            z_flag_reg <= 1'b0;
            shad_c_reg <= 1'b0;
            shad_z_reg <= 1'b0;
        end else begin
            c_flag_reg <= c_flag_next;
            z_flag_reg <= z_flag_next;
            shad_c_reg <= shad_c_next;
            shad_z_reg <= shad_z_next;
        end
    end

    assign bus.c_flag = c_flag_reg;
    assign bus.z_flag = z_flag_reg;
endmodule
